// File: rtl/stereo_line_arbiter.sv
// Stereo line arbiter: locks two AXI4-Stream cameras to a common SOF and
// forwards whole lines alternately (s0, s1, s0, ...) on one tagged output stream.
module stereo_line_arbiter #(
   parameter int unsigned LINES_PER_FRAME = 720,
   parameter int unsigned TIMEOUT_CYCLES  = 65535
) (
   input  logic        m_axis_video_aclk,
   input  logic        m_axis_video_aresetn,
   input  logic        enable,
   input  logic [15:0] s0_axis_video_tdata,
   input  logic        s0_axis_video_tvalid,
   output logic        s0_axis_video_tready,
   input  logic        s0_axis_video_tuser,
   input  logic        s0_axis_video_tlast,
   input  logic [15:0] s1_axis_video_tdata,
   input  logic        s1_axis_video_tvalid,
   output logic        s1_axis_video_tready,
   input  logic        s1_axis_video_tuser,
   input  logic        s1_axis_video_tlast,
   output logic [15:0] m_axis_video_tdata,
   output logic        m_axis_video_tvalid,
   input  logic        m_axis_video_tready,
   output logic        m_axis_video_tuser,
   output logic        m_axis_video_tlast,
   output logic        m_axis_video_tdest,
   output logic        locked,
   output logic [15:0] frame_cnt,
   output logic [7:0]  err_cnt
);

   localparam int unsigned DW = 16;
   localparam int unsigned TW = 16;
   localparam int unsigned EW = 8;
   localparam int unsigned LW = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;
   localparam logic [LW-1:0] LAST_LINE = LW'(LINES_PER_FRAME - 1);
   localparam logic [TW-1:0] IDLE_LIMIT = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {SYNC, SEND0, SEND1} state_t;

   state_t        state, state_nx;
   logic [LW-1:0] line_idx, line_nx;
   logic [TW-1:0] idle_cnt, idle_nx;
   logic [DW-1:0] frame_nx;
   logic [EW-1:0] err_nx;
   logic          held0, held0_nx, held1, held1_nx;
   logic          first, first_nx;

   logic          sel;
   logic [DW-1:0] src_data;
   logic          src_valid, src_user, src_last, sof_ok;

   // Source mux for the line currently being forwarded
   always_comb begin
      sel       = (state == SEND1);
      src_data  = sel ? s1_axis_video_tdata  : s0_axis_video_tdata;
      src_valid = sel ? s1_axis_video_tvalid : s0_axis_video_tvalid;
      src_user  = sel ? s1_axis_video_tuser  : s0_axis_video_tuser;
      src_last  = sel ? s1_axis_video_tlast  : s0_axis_video_tlast;
      sof_ok    = (src_user == (line_idx == '0));
   end

   // Next-state and pass-through datapath
   always_comb begin
      state_nx = state;
      line_nx  = line_idx;
      idle_nx  = idle_cnt;
      frame_nx = frame_cnt;
      err_nx   = err_cnt;
      held0_nx = held0;
      held1_nx = held1;
      first_nx = first;
      m_axis_video_tdata   = '0;
      m_axis_video_tvalid  = 1'b0;
      m_axis_video_tuser   = 1'b0;
      m_axis_video_tlast   = 1'b0;
      m_axis_video_tdest   = 1'b0;
      s0_axis_video_tready = 1'b0;
      s1_axis_video_tready = 1'b0;

      unique case (state)
         SYNC: begin
            // SOF beats are never accepted here; they wait at the input head
            s0_axis_video_tready = enable & ~held0 & ~s0_axis_video_tuser;
            s1_axis_video_tready = enable & ~held1 & ~s1_axis_video_tuser;
            held0_nx = held0 ? s0_axis_video_tvalid
                             : (enable & s0_axis_video_tvalid & s0_axis_video_tuser);
            held1_nx = held1 ? s1_axis_video_tvalid
                             : (enable & s1_axis_video_tvalid & s1_axis_video_tuser);
            if (held0 && held1 && enable) begin
               state_nx = SEND0;
               line_nx  = '0;
               held0_nx = 1'b0;
               held1_nx = 1'b0;
               first_nx = 1'b1;
               idle_nx  = '0;
            end
         end

         SEND0, SEND1: begin
            m_axis_video_tdest = sel;
            m_axis_video_tdata = src_data;
            m_axis_video_tlast = src_last;
            if (first && src_valid && !sof_ok) begin
               err_nx   = (err_cnt == '1) ? err_cnt : err_cnt + EW'(1);
               state_nx = SYNC;
            end else begin
               m_axis_video_tvalid = src_valid;
               m_axis_video_tuser  = ~sel & first & (line_idx == '0) & src_user;
               if (sel) s1_axis_video_tready = m_axis_video_tready;
               else     s0_axis_video_tready = m_axis_video_tready;
               if (src_valid && m_axis_video_tready) begin
                  idle_nx  = '0;
                  first_nx = src_last;
                  if (src_last && !sel) begin
                     state_nx = SEND1;
                  end else if (src_last) begin
                     state_nx = enable ? SEND0 : SYNC;
                     if (line_idx == LAST_LINE) begin
                        line_nx  = '0;
                        frame_nx = frame_cnt + DW'(1);
                     end else begin
                        line_nx = line_idx + LW'(1);
                     end
                  end
               end else if (!src_valid) begin
                  // Backpressure alone never advances the stall counter
                  if (idle_cnt == IDLE_LIMIT) begin
                     err_nx   = (err_cnt == '1) ? err_cnt : err_cnt + EW'(1);
                     state_nx = SYNC;
                  end else begin
                     idle_nx = idle_cnt + TW'(1);
                  end
               end
            end
         end

         default: state_nx = SYNC;
      endcase

      if (!m_axis_video_aresetn) begin
         m_axis_video_tdata   = '0;
         m_axis_video_tvalid  = 1'b0;
         m_axis_video_tuser   = 1'b0;
         m_axis_video_tlast   = 1'b0;
         m_axis_video_tdest   = 1'b0;
         s0_axis_video_tready = 1'b0;
         s1_axis_video_tready = 1'b0;
      end
   end

   // State register
   always_ff @(posedge m_axis_video_aclk) begin
      if (!m_axis_video_aresetn) begin
         state     <= SYNC;
         line_idx  <= '0;
         idle_cnt  <= '0;
         frame_cnt <= '0;
         err_cnt   <= '0;
         held0     <= 1'b0;
         held1     <= 1'b0;
         first     <= 1'b0;
         locked    <= 1'b0;
      end else begin
         state     <= state_nx;
         line_idx  <= line_nx;
         idle_cnt  <= idle_nx;
         frame_cnt <= frame_nx;
         err_cnt   <= err_nx;
         held0     <= held0_nx;
         held1     <= held1_nx;
         first     <= first_nx;
         locked    <= (state_nx != SYNC);
      end
   end

endmodule
